// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: the fetch unit asks with ren/addr and memory answers with an ack pulse and data.
interface instr_fetch_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_ren,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_ren,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: reads imem at the current PC, pulses iready once per word,
// and traps misaligned PCs or unanswered reads into a sticky error state.
module instr_fetch #(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [31:0]          pc_addr,
    input  logic                 halt,
    instr_fetch_if.master        imem,
    output logic                 iready,
    output logic [31:0]          instr,
    output logic                 halted,
    output logic                 bus_err,
    output logic                 misalign_err
);
    localparam int unsigned     CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        VALID,
        HALTED,
        ERROR
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      instr_q, instr_d;
    logic             bus_err_q, bus_err_d;
    logic             misalign_err_q, misalign_err_d;
    logic             ren_q;
    logic             iready_q;
    logic             halted_q;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        instr_d        = instr_q;
        bus_err_d      = bus_err_q;
        misalign_err_d = misalign_err_q;

        case (state_q)
            IDLE: begin
                addr_d = pc_addr;
                if (pc_addr[1:0] != 2'b00) begin
                    state_d        = ERROR;
                    misalign_err_d = 1'b1;
                end else if (halt) begin
                    state_d = HALTED;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // An ack on the last allowed cycle still completes the fetch.
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    cnt_d   = '0;
                    state_d = VALID;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    state_d   = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            VALID:   state_d = IDLE;
            HALTED:  if (!halt) state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            instr_q        <= RESET_INSTR;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
            ren_q          <= 1'b0;
            iready_q       <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            instr_q        <= instr_d;
            bus_err_q      <= bus_err_d;
            misalign_err_q <= misalign_err_d;
            // Status outputs are decoded from the next state so they are glitch-free flops.
            ren_q          <= (state_d == FETCH);
            iready_q       <= (state_d == VALID);
            halted_q       <= (state_d == HALTED);
        end
    end

    assign imem.imem_ren  = ren_q;
    assign imem.imem_addr = addr_q;
    assign iready         = iready_q;
    assign instr          = instr_q;
    assign halted         = halted_q;
    assign bus_err        = bus_err_q;
    assign misalign_err   = misalign_err_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: a default-timeout unit and a TIMEOUT=4 unit share stimulus.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] pc_addr;
    logic        halt;
    logic        ack;
    logic [31:0] rdata;

    logic        iready, halted, bus_err, misalign_err;
    logic [31:0] instr;
    logic        t_iready, t_halted, t_bus_err, t_misalign_err;
    logic [31:0] t_instr;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [31:0] exp_q[$];

    instr_fetch_if bus ();
    instr_fetch_if bus4 ();

    assign bus.imem_ack    = ack;
    assign bus.imem_rdata  = rdata;
    assign bus4.imem_ack   = ack;
    assign bus4.imem_rdata = rdata;

    instr_fetch dut (
        .clk          (clk),
        .nRST         (nRST),
        .pc_addr      (pc_addr),
        .halt         (halt),
        .imem         (bus.master),
        .iready       (iready),
        .instr        (instr),
        .halted       (halted),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    instr_fetch #(.TIMEOUT(4)) dut4 (
        .clk          (clk),
        .nRST         (nRST),
        .pc_addr      (pc_addr),
        .halt         (halt),
        .imem         (bus4.master),
        .iready       (t_iready),
        .instr        (t_instr),
        .halted       (t_halted),
        .bus_err      (t_bus_err),
        .misalign_err (t_misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ren"},      32'(bus.imem_ren),  32'd0);
        check({tag, "_addr"},     bus.imem_addr,      32'd0);
        check({tag, "_iready"},   32'(iready),        32'd0);
        check({tag, "_instr"},    instr,              NOP);
        check({tag, "_halted"},   32'(halted),        32'd0);
        check({tag, "_bus_err"},  32'(bus_err),       32'd0);
        check({tag, "_misalign"}, 32'(misalign_err),  32'd0);
    endtask

    // Leaves nRST released just after a rising edge, so the DUT spends the current cycle in IDLE.
    task automatic apply_reset(input logic [31:0] pc, input logic h);
        nRST    = 1'b0;
        ack     = 1'b0;
        rdata   = '0;
        pc_addr = pc;
        halt    = h;
        step();
        step();
        check_reset_vals("rst");
        nRST = 1'b1;
    endtask

    // Entered during an IDLE cycle; returns during the IDLE cycle after the VALID pulse.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int waits,
                         input logic raise_halt);
        pc_addr = pc;
        step();
        pc_addr = pc + 32'h100;
        for (int i = 0; i <= waits; i++) begin
            check("fetch_ren",    32'(bus.imem_ren), 32'd1);
            check("fetch_addr",   bus.imem_addr,     pc);
            check("fetch_iready", 32'(iready),       32'd0);
            if (raise_halt && i == 0) halt = 1'b1;
            if (i == waits) begin
                ack   = 1'b1;
                rdata = data;
                exp_q.push_back(data);
            end
            step();
        end
        ack   = 1'b0;
        rdata = $urandom;
        check("valid_iready",  32'(iready),       32'd1);
        check("valid_ren",     32'(bus.imem_ren), 32'd0);
        check("valid_bus_err", 32'(bus_err),      32'd0);
        if (iready && exp_q.size() > 0) check("sb_instr", instr, exp_q.pop_front());
        step();
        check("post_iready", 32'(iready), 32'd0);
        check("instr_hold",  instr,       data);
    endtask

    initial begin
        apply_reset(32'h0, 1'b0);
        fetch(32'h0, 32'h0050_0093, 0, 1'b0);

        fetch(32'h40, 32'h00A0_0113, 4, 1'b0);
        fetch(32'h44, 32'h1234_5678, 1, 1'b0);

        // halt raised mid-fetch: the fetch finishes, then the unit parks.
        fetch(32'h48, 32'hCAFE_0001, 2, 1'b1);
        step();
        check("halt_halted", 32'(halted),       32'd1);
        check("halt_ren",    32'(bus.imem_ren), 32'd0);
        ack   = 1'b1;
        rdata = 32'hDEAD_DEAD;
        step();
        ack = 1'b0;
        check("halt_still",        32'(halted), 32'd1);
        check("halt_ack_ignored",  instr,       32'hCAFE_0001);
        check("halt_no_iready",    32'(iready), 32'd0);
        halt    = 1'b0;
        pc_addr = 32'h80;
        step();
        check("unhalt_halted", 32'(halted), 32'd0);
        fetch(32'h80, 32'hCAFE_0002, 0, 1'b0);

        // Reset asserted mid-fetch takes effect without a clock edge.
        pc_addr = 32'h90;
        step();
        check("rstmid_ren_before", 32'(bus.imem_ren), 32'd1);
        nRST = 1'b0;
        #1;
        check_reset_vals("rstmid");
        ack   = 1'b1;
        rdata = 32'hBEEF_BEEF;
        step();
        step();
        check("rstmid_ack_instr",  instr,       NOP);
        check("rstmid_ack_iready", 32'(iready), 32'd0);
        ack  = 1'b0;
        nRST = 1'b1;
        fetch(32'h94, 32'h0000_1111, 1, 1'b0);

        // Misaligned PC traps on the first IDLE edge and never requests.
        apply_reset(32'h42, 1'b0);
        step();
        check("mis_err",     32'(misalign_err), 32'd1);
        check("mis_bus_err", 32'(bus_err),      32'd0);
        pc_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            ack   = i[0];
            rdata = 32'h5555_0000 + 32'(i);
            check("mis_ren",    32'(bus.imem_ren), 32'd0);
            check("mis_iready", 32'(iready),       32'd0);
            check("mis_sticky", 32'(misalign_err), 32'd1);
            step();
        end
        ack = 1'b0;
        check("mis_instr", instr, NOP);

        // Misalignment wins over halt.
        apply_reset(32'h41, 1'b1);
        step();
        check("prio_mis",    32'(misalign_err), 32'd1);
        check("prio_halted", 32'(halted),       32'd0);

        // TIMEOUT=4 unit: four unanswered FETCH cycles raise bus_err.
        apply_reset(32'h10, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("to_ren",     32'(bus4.imem_ren), 32'd1);
            check("to_no_err",  32'(t_bus_err),     32'd0);
            step();
        end
        check("to_bus_err",   32'(t_bus_err),     32'd1);
        check("to_ren_off",   32'(bus4.imem_ren), 32'd0);
        check("to_main_busy", 32'(bus.imem_ren),  32'd1);
        check("to_main_ok",   32'(bus_err),       32'd0);
        for (int i = 0; i < 3; i++) begin
            ack   = 1'b1;
            rdata = 32'h7777_0000 + 32'(i);
            step();
            check("to_sticky", 32'(t_bus_err),     32'd1);
            check("to_held",   32'(bus4.imem_ren), 32'd0);
            check("to_iready", 32'(t_iready),      32'd0);
        end
        ack = 1'b0;
        check("to_instr", t_instr, NOP);

        // Ack on the fourth FETCH cycle completes the fetch.
        apply_reset(32'h20, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("to4_ren", 32'(bus4.imem_ren), 32'd1);
            if (i == 3) begin
                ack   = 1'b1;
                rdata = 32'h0420_0513;
            end
            step();
        end
        ack = 1'b0;
        check("to4_iready",  32'(t_iready),  32'd1);
        check("to4_bus_err", 32'(t_bus_err), 32'd0);
        check("to4_instr",   t_instr,        32'h0420_0513);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
